mem_lsu: RTL
============

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the maximum number of BUS cycles to wait for bus_ack_i before aborting.
REQ-002 SHALL have ports clk_100M (in, 1): the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst (in, 1): reset, synchronous and active-high.
REQ-004 SHALL have inputs from the EX/MEM register:
- mem_r_ena_i (1)
- mem_r_addr_i (32)
- mem_w_ena_i (1)
- mem_w_addr_i (32)
- mem_w_data_i (32)
- inst_i (32): funct3 = inst_i[14:12]
- reg_w_ena_i (1)
- reg_w_addr_i (5)
- reg_w_data_i (32)
REQ-005 SHALL have bus outputs:
- bus_req_o (1)
- bus_we_o (1)
- bus_addr_o (32): word-aligned, [1:0]=00
- bus_be_o (4)
- bus_wdata_o (32)
REQ-006 SHALL have bus inputs bus_ack_i (in, 1) and bus_rdata_i (in, 32).
REQ-007 SHALL have MEM/WB outputs reg_w_ena_o (1), reg_w_addr_o (5) and reg_w_data_o (32).
REQ-008 SHALL have status outputs:
- hold_o (1): pipeline stall request
- bus_err_o (1): timeout pulse
- misalign_o (1): misalign pulse

Function
REQ-009 SHALL implement FSM states IDLE, BUS, RESP.
REQ-010 SHALL treat a request as present in IDLE when mem_r_ena_i or mem_w_ena_i is high.
- If both are high, the write wins and the read is dropped.
REQ-011 SHALL, in IDLE with a request, assert hold_o combinationally, register the access, and enter BUS.
- Registered fields: we, word address, byte enables, write data, funct3, addr[1:0], reg_w fields.
REQ-012 SHALL, in BUS, drive bus_req_o=1 with addr/we/be/wdata stable, and keep hold_o=1.
REQ-013 SHALL, when bus_ack_i=1 in BUS, capture bus_rdata_i and enter RESP.
- bus_req_o SHALL be 0 in the following cycle.
REQ-014 SHALL, in RESP, deassert hold_o and present the writeback outputs for exactly one cycle, then return to IDLE.
REQ-015 SHALL abort when TIMEOUT BUS cycles elapse without ack:
- pulse bus_err_o for one cycle;
- enter RESP with load data forced to 0.
REQ-016 SHALL, in IDLE with no request, pass reg_w_ena_i/addr_i/data_i to the outputs combinationally with hold_o=0 (zero-latency non-memory path).
REQ-017 SHALL force reg_w_ena_o=0 in RESP for stores, and for stores when passing through in IDLE.
REQ-018 SHALL, for loads in RESP, select the lane by the captured addr[1:0] and extend as follows:
- 000 LB: sign-extend byte
- 100 LBU: zero-extend byte
- 001 LH: sign-extend half, lane addr[1]
- 101 LHU: zero-extend half, lane addr[1]
- 010 LW: full word
REQ-019 SHALL decode store byte enables as follows:
- SB: be=0001<<addr[1:0], wdata = byte replicated x4
- SH: be=0011<<(2*addr[1]), wdata = half replicated x2
- SW: be=1111
REQ-020 SHALL treat reserved funct3 (011, 110, 111) as word accesses.
REQ-021 SHALL ignore bus_ack_i in IDLE and RESP.
REQ-022 SHALL give a memory op a minimum latency of 3 cycles (IDLE, BUS with ack, RESP), with hold_o high for the first 2.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, set the state to IDLE and clear all registered outputs and the captured data to 0.
- Registered outputs: bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, bus_err_o, misalign_o.
REQ-024 SHALL, on reset during BUS or RESP, abandon the access.
- bus_req_o=0 from the next cycle.
- A late ack SHALL produce no writeback.

Configuration
REQ-025 SHALL provide the macro MEM_LSU_MISALIGN_TRAP_EN to compile misalignment trapping in or out.
REQ-026 With MEM_LSU_MISALIGN_TRAP_EN defined, the misaligned cases SHALL be trapped.
- Misaligned cases: LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=00.
- The block SHALL skip BUS, go IDLE->RESP, and pulse misalign_o for one cycle.
- It SHALL issue no bus_req_o and SHALL force reg_w_ena_o=0.
REQ-027 Without MEM_LSU_MISALIGN_TRAP_EN, the block SHALL ignore the misaligned low bits.
- Halfword uses addr[1] only; word uses addr[31:2].
- misalign_o SHALL stay tied to 0.

Verification
REQ-028 Load, immediate ack: LW addr=0x100, ack in first BUS cycle, rdata=0xDEADBEEF -> bus_addr_o=0x100, be=1111, hold_o high 2 cycles, RESP reg_w_data_o=0xDEADBEEF.
REQ-029 Byte/half extension: LB addr=0x103, rdata=0x80xxxxxx -> 0xFFFFFF80; LHU addr=0x102, rdata=0x8001xxxx -> 0x00008001.
REQ-030 Store: SB addr=0x201, data=0x000000AB, ack after 3 wait cycles -> be=0010, wdata=0xABABABAB, bus_we_o=1, signals stable until ack, reg_w_ena_o=0.
REQ-031 Timeout: LW with no ack, TIMEOUT=15 -> bus_req_o high 15 cycles, bus_err_o 1-cycle pulse, reg_w_data_o=0 in RESP, back to IDLE.
REQ-032 Reset mid-access: rst in the 2nd BUS cycle -> next cycle IDLE, bus_req_o=0, hold_o=0, and an ack the following cycle is ignored.
REQ-033 Misalign: LW addr=0x102 -> with the macro, misalign_o pulse and no bus_req_o; without the macro, bus_addr_o=0x100 and be=1111.

Source files
------------

// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu -- load/store unit between the EX/MEM register and a simple
// request/acknowledge memory bus.
//
// Non-memory instructions pass straight through to the MEM/WB outputs in the
// same cycle. A load or store stalls the pipeline (hold_o) and runs a
// three-state sequence IDLE -> BUS -> RESP. In RESP the writeback is presented
// for exactly one cycle.
//
// Bus handshake: in BUS, bus_req_o is held high with bus_we_o, bus_addr_o,
// bus_be_o and bus_wdata_o stable until the first cycle in which bus_ack_i is
// high. That cycle completes the transfer, bus_rdata_i is captured on the same
// edge, and bus_req_o is low from the next cycle. bus_ack_i is ignored outside
// BUS. If no ack arrives within TIMEOUT BUS cycles the access is aborted,
// bus_err_o pulses and the load data is returned as zero.
//
// Parameters:
//   TIMEOUT       maximum number of BUS cycles to wait for bus_ack_i (>= 1)
//
// Optional feature (compile-time macro MEM_LSU_MISALIGN_TRAP_EN):
//   defined   : misaligned halfword/word accesses skip the bus, go straight to
//               RESP, pulse misalign_o and suppress the writeback.
//   undefined : misaligned low address bits are ignored; misalign_o is tied 0.
//
// Ports:
//   clk_100M, rst          clock, synchronous active-high reset
//   mem_r_ena_i/addr_i     load request and byte address
//   mem_w_ena_i/addr_i     store request and byte address (wins over a load)
//   mem_w_data_i           store data (low byte/half/word used per size)
//   inst_i                 instruction; funct3 = inst_i[14:12]
//   reg_w_ena/addr/data_i  register writeback fields from EX/MEM
//   bus_req/we/addr/be/wdata_o   memory bus request (registered)
//   bus_ack_i, bus_rdata_i       memory bus response
//   reg_w_ena/addr/data_o  writeback fields to MEM/WB
//   hold_o                 pipeline stall request
//   bus_err_o              one-cycle pulse on bus timeout
//   misalign_o             one-cycle pulse on a trapped misaligned access
//   dbg_state_o            current FSM state (0 IDLE, 1 BUS, 2 RESP)
// -----------------------------------------------------------------------------
module mem_lsu #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk_100M,
    input  logic        rst,
    input  logic        mem_r_ena_i,
    input  logic [31:0] mem_r_addr_i,
    input  logic        mem_w_ena_i,
    input  logic [31:0] mem_w_addr_i,
    input  logic [31:0] mem_w_data_i,
    input  logic [31:0] inst_i,
    input  logic        reg_w_ena_i,
    input  logic [4:0]  reg_w_addr_i,
    input  logic [31:0] reg_w_data_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        reg_w_ena_o,
    output logic [4:0]  reg_w_addr_o,
    output logic [31:0] reg_w_data_o,
    output logic        hold_o,
    output logic        bus_err_o,
    output logic        misalign_o,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]    r_state;
    logic          r_we;
    logic [29:0]   r_addr;
    logic [1:0]    r_lo;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic [2:0]    r_f3;
    logic          r_reg_w_ena;
    logic [4:0]    r_reg_w_addr;
    logic [31:0]   r_reg_w_data;
    logic [31:0]   r_rdata;
    logic [CW-1:0] r_cnt;
    logic          r_bus_req;
    logic          r_bus_err;

    logic          w_req;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [2:0]    w_f3;
    logic          w_is_byte;
    logic          w_is_half;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic          w_trap;
    logic          w_resp_trap;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic          w_unused_inst;

    // Only funct3 of the instruction matters here.
    assign w_unused_inst = ^{inst_i[31:15], inst_i[11:0]};

    // Request decode: a store takes priority over a simultaneous load.
    assign w_req  = mem_r_ena_i | mem_w_ena_i;
    assign w_we   = mem_w_ena_i;
    assign w_addr = w_we ? mem_w_addr_i : mem_r_addr_i;
    assign w_f3   = inst_i[14:12];

    // Size comes from funct3[1:0]; reserved encodings (x11, 110) fall to word.
    assign w_is_byte = (w_f3[1:0] == 2'b00);
    assign w_is_half = (w_f3[1:0] == 2'b01);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = mem_w_data_i;
        if (w_is_byte) begin
            w_be    = 4'b0001 << w_addr[1:0];
            w_wdata = {4{mem_w_data_i[7:0]}};
        end else if (w_is_half) begin
            w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{mem_w_data_i[15:0]}};
        end
    end

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_trap = (w_is_half & w_addr[0]) |
                    (~w_is_byte & ~w_is_half & (w_addr[1:0] != 2'b00));

    // High only during the RESP cycle of a trapped access.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= (r_state == S_IDLE) & w_req & w_trap;
        end
    end

    assign w_resp_trap = r_misalign;
    assign misalign_o  = r_misalign;
`else
    assign w_trap      = 1'b0;
    assign w_resp_trap = 1'b0;
    assign misalign_o  = 1'b0;
`endif

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_lo         <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_f3         <= '0;
            r_reg_w_ena  <= 1'b0;
            r_reg_w_addr <= '0;
            r_reg_w_data <= '0;
            r_rdata      <= '0;
            r_cnt        <= '0;
            r_bus_req    <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_bus_err <= 1'b0;
                    if (w_req) begin
                        r_we         <= w_we;
                        r_addr       <= w_addr[31:2];
                        r_lo         <= w_addr[1:0];
                        r_be         <= w_be;
                        r_wdata      <= w_wdata;
                        r_f3         <= w_f3;
                        r_reg_w_ena  <= reg_w_ena_i;
                        r_reg_w_addr <= reg_w_addr_i;
                        r_reg_w_data <= reg_w_data_i;
                        r_rdata      <= '0;
                        r_cnt        <= '0;
                        if (w_trap) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state   <= S_BUS;
                            r_bus_req <= 1'b1;
                        end
                    end
                end
                S_BUS: begin
                    if (bus_ack_i) begin
                        r_rdata   <= bus_rdata_i;
                        r_bus_req <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        // r_cnt counts completed BUS cycles, so this is the
                        // TIMEOUT-th cycle without an ack.
                        r_rdata   <= '0;
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    r_bus_err <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_bus_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // Load lane select and extension from the captured word.
    always_comb begin
        case (r_lo)
            2'd0:    w_byte = r_rdata[7:0];
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = r_lo[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (r_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = r_rdata;
        endcase
    end

    // Writeback mux: pass-through in IDLE, captured result in RESP.
    always_comb begin
        reg_w_ena_o  = 1'b0;
        reg_w_addr_o = '0;
        reg_w_data_o = '0;
        case (r_state)
            S_IDLE: begin
                reg_w_ena_o  = reg_w_ena_i & ~w_req;
                reg_w_addr_o = reg_w_addr_i;
                reg_w_data_o = reg_w_data_i;
            end
            S_RESP: begin
                reg_w_ena_o  = r_reg_w_ena & ~r_we & ~w_resp_trap;
                reg_w_addr_o = r_reg_w_addr;
                reg_w_data_o = r_we ? r_reg_w_data : w_load;
            end
            default: begin
                reg_w_ena_o  = 1'b0;
                reg_w_addr_o = '0;
                reg_w_data_o = '0;
            end
        endcase
    end

    assign hold_o      = ((r_state == S_IDLE) & w_req) | (r_state == S_BUS);
    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_we;
    assign bus_addr_o  = {r_addr, 2'b00};
    assign bus_be_o    = r_be;
    assign bus_wdata_o = r_wdata;
    assign bus_err_o   = r_bus_err;
    assign dbg_state_o = r_state;

endmodule
